fetch_sequencer: RTL and testbench

Fetch-stage controller that sequences the single-cycle combinational instruction memory. It holds the program counter, drives the word address into the memory and captures each returned instruction into a 2-entry output queue toward decode with a valid/ready handshake. It also handles start-up, branch/jump redirects (queue flush) and out-of-range or misaligned PC faults. It sits between the instruction memory and the decode stage.

---
 rtl/fetch_sequencer_pkg.sv | 12 +
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer_queue.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 90 +++++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int QDEPTH = 2;   // output queue entries toward decode
  localparam int CNT_W  = 2;   // wide enough to hold 0..QDEPTH
  localparam int INST_W = 32;  // instruction word width
endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory and decode-side signals of the fetch stage.
// master = fetch_sequencer, slave = memory/decode/branch unit side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int N = INST_W
);
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_inst;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_inst;
  logic [N-1:0] out_pc;

  modport master (
    output imem_addr, out_valid, out_inst, out_pc,
    input  imem_inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc,
    output imem_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_sequencer_queue.sv
// fetch_queue: 2-entry FIFO of {inst, pc}. Head lives in slot 0.
// Flush wins over push and pop; a pop on an empty queue is ignored.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int N = INST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [N-1:0]     i_inst,
  input  logic [N-1:0]     i_pc,
  output logic             o_valid,
  output logic [N-1:0]     o_inst,
  output logic [N-1:0]     o_pc,
  output logic [CNT_W-1:0] o_count
);
  logic [QDEPTH-1:0][N-1:0] r_inst;
  logic [QDEPTH-1:0][N-1:0] r_pc;
  logic [CNT_W-1:0]         r_count;
  logic                     w_pop;
  logic                     w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // a push into a full queue is only legal when the head leaves the same cycle
  assign w_push = i_push && ((r_count < CNT_W'(QDEPTH)) || w_pop);

  // storage and occupancy update; same-cycle push+pop keeps order and count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) begin
            r_inst[0] <= i_inst;
            r_pc[0]   <= i_pc;
          end else begin
            r_inst[1] <= i_inst;
            r_pc[1]   <= i_pc;
          end
          r_count <= r_count + CNT_W'(1);
        end
        2'b01: begin
          r_inst[0] <= r_inst[1];
          r_pc[0]   <= r_pc[1];
          r_count   <= r_count - CNT_W'(1);
        end
        2'b11: begin
          if (r_count == CNT_W'(1)) begin
            r_inst[0] <= i_inst;
            r_pc[0]   <= i_pc;
          end else begin
            r_inst[0] <= r_inst[1];
            r_pc[0]   <= r_pc[1];
            r_inst[1] <= i_inst;
            r_pc[1]   <= i_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_inst  = r_inst[0];
  assign o_pc    = r_pc[0];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: PC, IDLE/RUN/FAULT sequencing, redirect flush,
// and a 2-deep queue of fetched instructions toward decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          N        = INST_W,
  parameter int          M        = 1024,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  fetch_sequencer_if.master  bus,
  output logic               o_fault,
  output logic [N-1:0]       o_fetch_count
);
  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_pc;
  logic [N-1:0]     r_fetch_count;
  logic [CNT_W-1:0] w_count;
  logic             w_redir;
  logic             w_illegal;
  logic             w_pop;
  logic             w_room;
  logic             w_push;

  // redirect only counts once fetching has been started
  assign w_redir   = bus.redirect_valid && (r_state != ST_IDLE);
  // the range check also catches a pc that wrapped past the top of memory
  assign w_illegal = (r_pc[1:0] != 2'b00) || ((r_pc >> 2) >= N'(M));
  assign w_pop     = bus.out_valid && bus.out_ready;
  assign w_room    = (w_count < CNT_W'(QDEPTH)) || w_pop;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state: redirect beats everything outside IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_RUN;
      ST_RUN: begin
        if (w_redir)        w_next = ST_RUN;
        else if (w_illegal) w_next = ST_FAULT;
      end
      ST_FAULT: if (w_redir) w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
  end

  // outputs: fault flag, memory address, push enable
  always_comb begin
    o_fault       = (r_state == ST_FAULT);
    bus.imem_addr = r_pc >> 2;
    w_push        = (r_state == ST_RUN) && !w_redir && !w_illegal && w_room;
  end

  // pc and fetch counter; both wrap naturally at 2^N
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= N'(RESET_PC);
      r_fetch_count <= '0;
    end else if (w_redir) begin
      r_pc          <= bus.redirect_pc;
    end else if (w_push) begin
      r_pc          <= r_pc + N'(4);
      r_fetch_count <= r_fetch_count + N'(1);
    end
  end

  assign o_fetch_count = r_fetch_count;

  fetch_queue #(.N(N)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_inst  (bus.imem_inst),
    .i_pc    (r_pc),
    .o_valid (bus.out_valid),
    .o_inst  (bus.out_inst),
    .o_pc    (bus.out_pc),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// checked against a queue-based reference model plus a delivery scoreboard.
module tb_fetch_sequencer;
  localparam int N  = 32;
  localparam int MW = 20;  // memory words; 0x40 is in range, 0x50 is not

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         fault;
  logic [N-1:0] fcnt;
  logic [N-1:0] mem [MW];

  fetch_sequencer_if #(.N(N)) bus ();

  fetch_sequencer #(.N(N), .M(MW), .RESET_PC(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .bus           (bus.master),
    .o_fault       (fault),
    .o_fetch_count (fcnt)
  );

  always #5 clk = ~clk;

  // combinational instruction memory
  always_comb begin
    if (bus.imem_addr < MW) bus.imem_inst = mem[bus.imem_addr];
    else                    bus.imem_inst = 32'hDEAD_BEEF;
  end

  // reference model: mode 0=idle 1=running 2=faulted, queue of {inst,pc}
  int           m_mode = 0;
  logic [31:0]  m_pc   = 0;
  logic [31:0]  m_fc   = 0;
  logic [63:0]  mq[$];
  logic [63:0]  sb[$];
  logic [63:0]  mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_deliv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance the model by one clock using the inputs applied during that clock
  task automatic model_step();
    bit pop;
    if (reset) begin
      mq.delete(); m_pc = 0; m_fc = 0; m_mode = 0;
      return;
    end
    pop = (mq.size() > 0) && bus.out_ready;
    if (m_mode != 0 && bus.redirect_valid) begin
      mq.delete(); m_pc = bus.redirect_pc; m_mode = 1;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if ((m_pc % 4) != 0 || (m_pc / 4) >= MW) m_mode = 2;
      else if (mq.size() < 2) begin
        mq.push_back({mem[m_pc / 4], m_pc});
        m_pc = m_pc + 4;
        m_fc = m_fc + 1;
      end
    end
  endtask

  // one cycle: update model, drive new inputs, queue the expected delivery
  task automatic cyc(input bit st, input bit rv, input logic [31:0] rp,
                     input bit rdy, input bit rs);
    @(posedge clk); #1;
    model_step();
    start = st; bus.redirect_valid = rv; bus.redirect_pc = rp;
    bus.out_ready = rdy; reset = rs;
    if (!rs && !(rv && m_mode != 0) && mq.size() > 0 && rdy)
      sb.push_back(mq[0]);
  endtask

  task automatic run(input int n, input bit rdy);
    repeat (n) cyc(0, 0, 0, rdy, 0);
  endtask

  // monitor: state checks every cycle, scoreboard on each accepted delivery
  always @(negedge clk) begin
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    chk("fault", {31'd0, fault}, {31'd0, m_mode == 2});
    chk("fetch_count", fcnt, m_fc);
    chk("imem_addr", bus.imem_addr, m_pc >> 2);
    if (bus.out_valid && bus.out_ready && !reset && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL delivery: got pc %h with no expected entry at %0t", bus.out_pc, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("out_inst", bus.out_inst, mon_e[63:32]);
        chk("out_pc", bus.out_pc, mon_e[31:0]);
        n_deliv++;
      end
    end
    chk("sb_pending", sb.size(), 0);
    sb.delete();
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    for (int i = 0; i < MW; i++) mem[i] = (i < 4) ? 32'hA0 + i : $urandom;

    // reset, then stream A0..A3 with decode always ready
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h40, 1, 0);          // redirect in IDLE is ignored
    cyc(1, 0, 0, 1, 0);
    run(6, 1);

    // back-pressure: queue fills, pc holds at 8, then drains without bubble
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    run(5, 0);
    run(4, 1);

    // full queue, redirect to 0x40 while popping; run on into range fault
    run(3, 0);
    cyc(1, 1, 32'h40, 1, 0);          // start outside IDLE is ignored
    run(8, 1);
    run(3, 0);                        // fault holds, pc stays at 0x50

    // redirect out of fault back to 0
    cyc(0, 1, 32'h0, 1, 0);
    run(4, 1);

    // misaligned target faults with nothing pushed
    cyc(0, 1, 32'h6, 1, 0);
    run(3, 1);

    // reset with a full queue and a redirect pending in the same cycle
    cyc(0, 1, 32'h0, 0, 0);
    run(3, 0);
    cyc(0, 1, 32'h40, 1, 1);
    run(2, 1);

    // randomized traffic
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      case ($urandom_range(9))
        0:       rp = {25'd0, 5'($urandom_range(MW - 1)), 2'b10};
        1:       rp = 32'h100 + 4 * $urandom_range(15);
        2:       rp = 32'hFFFF_FFFC;
        default: rp = 4 * $urandom_range(MW - 1);
      endcase
      cyc($urandom_range(19) == 0, $urandom_range(99) < 8, rp,
          $urandom_range(9) < 7, $urandom_range(199) == 0);
    end
    run(4, 1);
    @(negedge clk); #1;
    if (n_deliv < 50) begin
      n_cmp++; n_bad++;
      $display("FAIL deliveries: got %0d expected at least 50", n_deliv);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
